sram_confreg_resp: RTL and testbench

- Responder for the CPU core's data-side SRAM port (en / 4-bit byte write enable / addr / wdata / rdata).
- Serves a word-addressed on-chip RAM plus a small memory-mapped register block: LEDs, switches, a timer with compare and an interrupt flag.
- Fixed 1-cycle read latency, so the core's MEM stage samples rdata the cycle after EX issues the access; there is no wait or stall signal.
- Sits at the SoC top beside the instruction SRAM, wired directly to the core's data_sram_* signals.

---
 rtl/sram_confreg_resp_if.sv | 31 +++
 rtl/sram_confreg_resp.sv | 136 +++++++++++++
 tb/tb_sram_confreg_resp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_confreg_resp_if.sv
// Data-side SRAM port between the CPU core and its memory/register responder.
// Signals:
//   sram_en    - access request this cycle
//   sram_wen   - byte write enables (lane i = wdata[8i+7:8i]); 0 means read
//   sram_addr  - byte address (bits [1:0] ignored by the responder)
//   sram_wdata - write data
//   sram_rdata - registered read data, valid the cycle after a read request
// Modports: master (core side), slave (responder side).
interface sram_confreg_resp_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_confreg_resp.sv
// Responder for the core's data SRAM port: word-addressed on-chip RAM plus a
// small register block (LED, switches, free-running timer with compare, and a
// sticky interrupt flag). Fixed one-cycle read latency, no stall.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   bus       - data SRAM port (slave modport)
//   switch_in - asynchronous board switches
//   led_out   - LED register
//   timer_irq - level interrupt, registered copy of STATUS.pending
module sram_confreg_resp #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
    parameter logic [31:0] TIMER_RST = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_confreg_resp_if.slave         bus,
    input  logic [7:0]                 switch_in,
    output logic [15:0]                led_out,
    output logic                       timer_irq
);

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_COMPARE = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;

    logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_timer;
    logic [31:0]       r_compare;
    logic              r_pending;
    logic [7:0]        r_sw_s1;
    logic [7:0]        r_sw_s2;

    logic              w_is_mmio;
    logic [15:0]       w_off;
    logic [ADDR_W-1:0] w_ram_idx;
    logic              w_rd;
    logic              w_wr;
    logic              w_wr_mmio;
    logic              w_wr_full;
    logic              w_match;
    logic              w_clr;
    logic [31:0]       w_rd_data;
    logic              w_unused_addr_lsb;

    assign w_is_mmio = (bus.sram_addr[31:16] == MMIO_BASE[31:16]);
    // Registers are word-sized; byte offset within the word is ignored.
    assign w_off     = {bus.sram_addr[15:2], 2'b00};
    assign w_ram_idx = bus.sram_addr[ADDR_W+1:2];
    assign w_rd      = bus.sram_en && (bus.sram_wen == 4'b0000);
    assign w_wr      = bus.sram_en && (bus.sram_wen != 4'b0000);
    assign w_wr_mmio = w_wr && w_is_mmio;
    assign w_wr_full = (bus.sram_wen == 4'b1111);
    assign w_unused_addr_lsb = ^bus.sram_addr[1:0];

    // A zero COMPARE disables matching so the timer passing through 0 after
    // reset does not raise an interrupt.
    assign w_match = (r_compare != 32'h0) && (r_timer == r_compare);
    assign w_clr   = w_wr_mmio && (w_off == OFF_STATUS) &&
                     bus.sram_wen[0] && bus.sram_wdata[0];

    always_comb begin
        w_rd_data = 32'h0;
        if (w_is_mmio) begin
            case (w_off)
                OFF_LED:     w_rd_data = {16'h0, r_led};
                OFF_SWITCH:  w_rd_data = {24'h0, r_sw_s2};
                OFF_TIMER:   w_rd_data = r_timer;
                OFF_COMPARE: w_rd_data = r_compare;
                OFF_STATUS:  w_rd_data = {31'h0, r_pending};
                default:     w_rd_data = 32'h0;
            endcase
        end else begin
            w_rd_data = r_mem[w_ram_idx];
        end
    end

    // RAM storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_wr && !w_is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_wen[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata   <= 32'h0;
            r_led     <= 16'h0;
            r_timer   <= TIMER_RST;
            r_compare <= 32'h0;
            r_pending <= 1'b0;
            r_sw_s1   <= 8'h0;
            r_sw_s2   <= 8'h0;
        end else begin
            r_sw_s1 <= switch_in;
            r_sw_s2 <= r_sw_s1;

            if (w_rd) begin
                r_rdata <= w_rd_data;
            end

            if (w_wr_mmio && (w_off == OFF_LED)) begin
                if (bus.sram_wen[0]) r_led[7:0]  <= bus.sram_wdata[7:0];
                if (bus.sram_wen[1]) r_led[15:8] <= bus.sram_wdata[15:8];
            end

            // A software write takes priority over the increment for one cycle.
            if (w_wr_mmio && (w_off == OFF_TIMER) && w_wr_full) begin
                r_timer <= bus.sram_wdata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end

            if (w_wr_mmio && (w_off == OFF_COMPARE) && w_wr_full) begin
                r_compare <= bus.sram_wdata;
            end

            // Set beats a simultaneous clear.
            r_pending <= w_match | (r_pending & ~w_clr);
        end
    end

    assign bus.sram_rdata = r_rdata;
    assign led_out        = r_led;
    assign timer_irq      = r_pending;

endmodule

// File: tb/tb_sram_confreg_resp.sv
module tb_sram_confreg_resp;

    localparam logic [31:0] A_LED     = 32'hBFAF_0000;
    localparam logic [31:0] A_SWITCH  = 32'hBFAF_0004;
    localparam logic [31:0] A_TIMER   = 32'hBFAF_0008;
    localparam logic [31:0] A_COMPARE = 32'hBFAF_000C;
    localparam logic [31:0] A_STATUS  = 32'hBFAF_0010;
    localparam logic [31:0] A_UNMAP   = 32'hBFAF_0020;

    logic        clk;
    logic        rst;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic        timer_irq;
    logic [31:0] rd;

    int n_vec;
    int n_err;

    sram_confreg_resp_if bus ();

    sram_confreg_resp #(
        .ADDR_W    (10),
        .MMIO_BASE (32'hBFAF_0000),
        .TIMER_RST (32'h0000_0000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
        bus.sram_en    = 1'b1;
        bus.sram_wen   = wen;
        bus.sram_addr  = addr;
        bus.sram_wdata = data;
        tick();
        bus_idle();
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        bus.sram_en    = 1'b1;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = addr;
        bus.sram_wdata = 32'h0;
        tick();
        bus_idle();
        data = bus.sram_rdata;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        switch_in = 8'h00;
        bus_idle();

        #2;
        check("rst_rdata", bus.sram_rdata, 32'h0);
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // RAM full write, read latency, hold on write/idle
        do_write(32'h0000_0040, 4'b1111, 32'h1234_5678);
        check("wr_hold", bus.sram_rdata, 32'h0);
        do_read(32'h0000_0040, rd);
        check("ram_rd", rd, 32'h1234_5678);
        tick();
        check("idle_hold", bus.sram_rdata, 32'h1234_5678);

        // byte lanes and alias
        do_write(32'h0000_0044, 4'b1111, 32'h1122_3344);
        do_write(32'h0000_0044, 4'b0101, 32'hAABB_CCDD);
        do_read(32'h0000_0044, rd);
        check("ram_lanes", rd, 32'h11BB_33DD);
        do_read(32'h0000_1040, rd);
        check("ram_alias", rd, 32'h1234_5678);

        // LED byte enables
        do_write(A_LED, 4'b0001, 32'hFFFF_A5C3);
        check("led_lo", {16'h0, led_out}, 32'h0000_00C3);
        do_write(A_LED, 4'b0010, 32'hFFFF_A5C3);
        check("led_hi", {16'h0, led_out}, 32'h0000_A5C3);
        do_write(A_LED, 4'b1100, 32'h0000_0000);
        check("led_upper_wen", {16'h0, led_out}, 32'h0000_A5C3);
        do_read(A_LED, rd);
        check("led_rd", rd, 32'h0000_A5C3);

        // switch synchronizer: two edges of delay before it is visible
        switch_in = 8'h5A;
        do_read(A_SWITCH, rd);
        check("sw_sync0", rd, 32'h0);
        do_read(A_SWITCH, rd);
        check("sw_sync1", rd, 32'h0);
        do_read(A_SWITCH, rd);
        check("sw_sync2", rd, 32'h0000_005A);
        do_write(A_SWITCH, 4'b1111, 32'hFFFF_FFFF);
        do_read(A_SWITCH, rd);
        check("sw_wr_ign", rd, 32'h0000_005A);

        // timer wrap on consecutive reads
        do_write(A_TIMER, 4'b1111, 32'hFFFF_FFFE);
        do_read(A_TIMER, rd);
        check("tmr_rd0", rd, 32'hFFFF_FFFE);
        do_read(A_TIMER, rd);
        check("tmr_rd1", rd, 32'hFFFF_FFFF);
        do_read(A_TIMER, rd);
        check("tmr_wrap", rd, 32'h0000_0000);

        // partial timer write ignored
        do_write(A_TIMER, 4'b1111, 32'h0000_0100);
        do_write(A_TIMER, 4'b0011, 32'h1234_5678);
        do_read(A_TIMER, rd);
        check("tmr_partial", rd, 32'h0000_0101);

        // interrupt: 17 edges after the timer write
        do_write(A_COMPARE, 4'b1111, 32'h0000_0020);
        do_read(A_COMPARE, rd);
        check("cmp_rd", rd, 32'h0000_0020);
        do_write(A_TIMER, 4'b1111, 32'h0000_0010);
        for (int i = 0; i < 16; i++) tick();
        check("irq_before", {31'h0, timer_irq}, 32'h0);
        tick();
        check("irq_rise", {31'h0, timer_irq}, 32'h1);
        do_read(A_STATUS, rd);
        check("status_rd", rd, 32'h0000_0001);
        do_write(A_STATUS, 4'b0001, 32'h0000_0001);
        check("irq_clr", {31'h0, timer_irq}, 32'h0);

        // COMPARE == 0 disables matching even when timer is 0
        do_write(A_COMPARE, 4'b1111, 32'h0000_0000);
        do_write(A_TIMER, 4'b1111, 32'h0000_0000);
        tick();
        tick();
        check("cmp0_disable", {31'h0, timer_irq}, 32'h0);

        // unmapped offset reads zero
        do_read(A_LED, rd);
        do_read(A_UNMAP, rd);
        check("unmapped_rd", rd, 32'h0);

        // clear on the match cycle: set wins
        do_write(A_COMPARE, 4'b1111, 32'h0000_0020);
        do_write(A_TIMER, 4'b1111, 32'h0000_0010);
        for (int i = 0; i < 16; i++) tick();
        do_write(A_STATUS, 4'b0001, 32'h0000_0001);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);

        // reset mid-read
        do_read(A_LED, rd);
        check("led_rd2", rd, 32'h0000_A5C3);
        bus.sram_en   = 1'b1;
        bus.sram_wen  = 4'b0000;
        bus.sram_addr = A_LED;
        #2;
        rst = 1'b0;
        #1;
        check("arst_rdata", bus.sram_rdata, 32'h0);
        check("arst_led", {16'h0, led_out}, 32'h0);
        check("arst_irq", {31'h0, timer_irq}, 32'h0);
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_read(A_TIMER, rd);
        check("rel_tmr0", rd, 32'h0000_0000);
        do_read(A_TIMER, rd);
        check("rel_tmr1", rd, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
